// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - command codes, FSM encodings and frame layout for spi_ram_ctrl
package spi_ram_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_TX_HOLD = 1'b1;

    typedef struct packed {
        logic [1:0]        cmd;
        logic [DATA_W-1:0] payload;
    } frame_t;

endpackage

// File: rtl/spi_ram_mem.sv
// rtl/spi_ram_mem.sv - single-port RAM, synchronous write, registered read, no reset on the array
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    // rdata only moves on a read, so the last read word is held indefinitely
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem_q[addr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - SPI-slave-facing RAM command decoder; optional SPI_RAM_AUTOINC_EN post-increments pointers
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] din,
    input  logic               rx_valid,
    output logic [DATA_W-1:0]  dout,
    output logic               tx_valid,
    output logic               cmd_err
);

    frame_t                 frame;
    logic                   rise;
    logic [ADDR_SIZE-1:0]   addr_pl;
    logic                   is_wr_addr, is_wr_data, is_rd_addr, is_rd_data;
    logic                   do_write, do_read;

    logic                   rx_valid_q;
    logic [ADDR_SIZE-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0]   rd_ptr_q, rd_ptr_d;
    logic                   wr_ok_q, wr_ok_d;
    logic                   rd_ok_q, rd_ok_d;
    logic                   cmd_err_q, cmd_err_d;
    logic                   rd_seen_q, rd_seen_d;
    logic [0:0]             state_q, state_d;

    logic [ADDR_SIZE-1:0]   mem_addr;
    logic [DATA_W-1:0]      mem_rdata;

    assign frame   = frame_t'(din);
    assign rise    = rx_valid & ~rx_valid_q;
    assign addr_pl = frame.payload[ADDR_SIZE-1:0];

    assign is_wr_addr = rise && (frame.cmd == CMD_WR_ADDR);
    assign is_wr_data = rise && (frame.cmd == CMD_WR_DATA);
    assign is_rd_addr = rise && (frame.cmd == CMD_RD_ADDR);
    assign is_rd_data = rise && (frame.cmd == CMD_RD_DATA);

    assign do_write = is_wr_data & wr_ok_q;
    assign do_read  = is_rd_data & rd_ok_q;

    // Only one command executes per edge, so the single RAM port can be muxed on cmd
    assign mem_addr = (frame.cmd == CMD_WR_DATA) ? wr_ptr_q : rd_ptr_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ok_d   = wr_ok_q;
        rd_ok_d   = rd_ok_q;
        rd_seen_d = rd_seen_q | do_read;
        cmd_err_d = (is_wr_data & ~wr_ok_q) | (is_rd_data & ~rd_ok_q);

        if (is_wr_addr) begin
            wr_ptr_d = addr_pl;
            wr_ok_d  = 1'b1;
        end
        if (is_rd_addr) begin
            rd_ptr_d = addr_pl;
            rd_ok_d  = 1'b1;
        end
`ifdef SPI_RAM_AUTOINC_EN
        // Pointer width equals log2(MEM_DEPTH), so natural overflow is the wrap
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        if (rise) begin
            state_d = do_read ? ST_TX_HOLD : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ok_q    <= 1'b0;
            rd_ok_q    <= 1'b0;
            cmd_err_q  <= 1'b0;
            rd_seen_q  <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            rx_valid_q <= rx_valid;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ok_q    <= wr_ok_d;
            rd_ok_q    <= rd_ok_d;
            cmd_err_q  <= cmd_err_d;
            rd_seen_q  <= rd_seen_d;
            state_q    <= state_d;
        end
    end

    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk   (clk),
        .we    (do_write),
        .re    (do_read),
        .addr  (mem_addr),
        .wdata (frame.payload),
        .rdata (mem_rdata)
    );

    // The read register itself is not reset; masking it gives dout its zero reset value
    assign dout     = rd_seen_q ? mem_rdata : '0;
    assign tx_valid = (state_q == ST_TX_HOLD);
    assign cmd_err  = cmd_err_q;

endmodule
